// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the MIPS32 pipelined core.
//
// This block sits beside the ID/EX pipeline registers. It provides these
// functions:
//   - Per-operand EX forward selects. MEM has priority over WB, and
//     register 0 is never forwarded.
//   - Load-use stall sequencing. It inserts LOAD_LAT bubbles in total: the
//     first bubble is in the detect cycle, and the rest come from LU_STALL.
//   - A full pipeline freeze while data memory is busy (mem_stall). This has
//     the highest priority.
//   - Branch-flush handling. A flush squashes IF/ID and abandons any
//     load-use stall that is in progress.
//   - A saturating count of cycles in which the PC was held.
//
// Ports:
//   clk, rstb      rising-edge clock, asynchronous active-low reset
//   id_*           ID-stage instruction: valid, source regs, source-use mask
//   ex_*           EX-stage source regs, destination, write enable, is-load
//   mem_rd/wr_en   MEM-stage destination and write enable
//   wb_rd/wr_en    WB-stage destination and write enable
//   mem_stall      data memory busy; freezes the whole pipe
//   flush_req      taken branch/jump resolved in EX
//   stat_clr       synchronous clear of stall_cnt
//   fwd_sel        2 bits per EX operand: 10 MEM, 01 WB, 00 register file
//   stall_pc, stall_ifid, bubble_idex, flush_ifid   pipeline control
//   lu_busy        load-use stall in progress (LU_STALL state)
//   stall_cnt      saturating stalled-cycle counter
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_use,
   input  logic [NUM_SRC*REG_AW-1:0] ex_src,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic                      ex_wr_en,
   input  logic                      ex_is_load,
   input  logic [REG_AW-1:0]         mem_rd,
   input  logic                      mem_wr_en,
   input  logic [REG_AW-1:0]         wb_rd,
   input  logic                      wb_wr_en,
   input  logic                      mem_stall,
   input  logic                      flush_req,
   input  logic                      stat_clr,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      stall_pc,
   output logic                      stall_ifid,
   output logic                      bubble_idex,
   output logic                      flush_ifid,
   output logic                      lu_busy,
   output logic [CNT_W-1:0]          stall_cnt
);

   typedef enum logic [0:0] {IDLE = 1'b0, LU_STALL = 1'b1} state_t;

   // The detect cycle supplies the first bubble.
   // LU_STALL therefore covers the remaining LOAD_LAT-1 bubbles.
   localparam logic [1:0] LU_CNT_INIT = 2'(LOAD_LAT - 1);

   state_t             state_q, state_d;
   logic [1:0]         lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               lu_hit;

   // This is true when a writing stage targets a non-zero register equal to src.
   function automatic logic reg_match(input logic              wr_en,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] src);
      reg_match = wr_en && (rd != '0) && (rd == src);
   endfunction

   // Compute the per-operand forward select; MEM wins over WB.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (reg_match(mem_wr_en, mem_rd, ex_src[i*REG_AW +: REG_AW])) begin
            fwd_sel[2*i +: 2] = 2'b10;
         end else if (reg_match(wb_wr_en, wb_rd, ex_src[i*REG_AW +: REG_AW])) begin
            fwd_sel[2*i +: 2] = 2'b01;
         end else begin
            fwd_sel[2*i +: 2] = 2'b00;
         end
      end
   end

   // Detect a load-use hazard: ID reads the register that the EX load writes.
   always_comb begin
      lu_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_src_use[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd)) begin
            lu_hit = 1'b1;
         end else begin
            lu_hit = lu_hit;
         end
      end
      lu_hit = lu_hit && id_valid && ex_wr_en && ex_is_load && (ex_rd != '0);
   end

   // Compute the FSM next state and the pipeline controls.
   // The priority order is mem_stall, then flush_req, then the load-use sequencing.
   always_comb begin
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      if (mem_stall) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
      end else if (flush_req) begin
         // A flush squashes the dependent instruction, so the load-use stall is dropped.
         flush_ifid  = 1'b1;
         bubble_idex = 1'b1;
         state_d     = IDLE;
         lu_cnt_d    = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lu_hit) begin
                  stall_pc    = 1'b1;
                  stall_ifid  = 1'b1;
                  bubble_idex = 1'b1;
                  if (LU_CNT_INIT != 2'd0) begin
                     state_d  = LU_STALL;
                     lu_cnt_d = LU_CNT_INIT;
                  end else begin
                     state_d  = IDLE;
                     lu_cnt_d = 2'd0;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            LU_STALL: begin
               stall_pc    = 1'b1;
               stall_ifid  = 1'b1;
               bubble_idex = 1'b1;
               // lu_cnt counts the bubbles still owed, including this one.
               if (lu_cnt_q <= 2'd1) begin
                  state_d  = IDLE;
                  lu_cnt_d = 2'd0;
               end else begin
                  lu_cnt_d = lu_cnt_q - 2'd1;
               end
            end
            default: begin
               state_d  = IDLE;
               lu_cnt_d = 2'd0;
            end
         endcase
      end
   end

   // Compute the next value of the saturating stall counter; a clear wins over an increment.
   always_comb begin
      if (stat_clr) begin
         stall_cnt_d = '0;
      end else if (stall_pc && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Register the state: the FSM, the bubble counter and the statistics.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         lu_cnt_q    <= 2'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign lu_busy   = (state_q == LU_STALL);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl. There are four instances, and all of
// them share the same inputs:
//   u0  LOAD_LAT=1
//   u1  LOAD_LAT=2
//   u2  LOAD_LAT=3
//   u3  LOAD_LAT=3 with CNT_W=4
// Each scenario resets all instances and then checks one of them. The driver
// pushes the hand-computed expected outputs for each cycle. The monitor pops
// these values on the falling edge and compares them.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rstb;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [1:0]  id_src_use;
   logic [9:0]  ex_src;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
   logic        mem_stall, flush_req, stat_clr;

   logic [3:0]  fwd0, fwd1, fwd2, fwd3;
   logic        sp0, sp1, sp2, sp3, si0, si1, si2, si3;
   logic        bb0, bb1, bb2, bb3, fl0, fl1, fl2, fl3, lb0, lb1, lb2, lb3;
   logic [15:0] cnt0, cnt1, cnt2;
   logic [3:0]  cnt3;

   typedef struct {
      int          inst;
      logic [24:0] v;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.LOAD_LAT(1)) u0 (
      .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .mem_stall(mem_stall), .flush_req(flush_req), .stat_clr(stat_clr),
      .fwd_sel(fwd0), .stall_pc(sp0), .stall_ifid(si0), .bubble_idex(bb0),
      .flush_ifid(fl0), .lu_busy(lb0), .stall_cnt(cnt0));

   hazard_fwd_ctrl #(.LOAD_LAT(2)) u1 (
      .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .mem_stall(mem_stall), .flush_req(flush_req), .stat_clr(stat_clr),
      .fwd_sel(fwd1), .stall_pc(sp1), .stall_ifid(si1), .bubble_idex(bb1),
      .flush_ifid(fl1), .lu_busy(lb1), .stall_cnt(cnt1));

   hazard_fwd_ctrl #(.LOAD_LAT(3)) u2 (
      .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .mem_stall(mem_stall), .flush_req(flush_req), .stat_clr(stat_clr),
      .fwd_sel(fwd2), .stall_pc(sp2), .stall_ifid(si2), .bubble_idex(bb2),
      .flush_ifid(fl2), .lu_busy(lb2), .stall_cnt(cnt2));

   hazard_fwd_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u3 (
      .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .mem_stall(mem_stall), .flush_req(flush_req), .stat_clr(stat_clr),
      .fwd_sel(fwd3), .stall_pc(sp3), .stall_ifid(si3), .bubble_idex(bb3),
      .flush_ifid(fl3), .lu_busy(lb3), .stall_cnt(cnt3));

   // Pack one instance's outputs as {fwd, stall_pc, stall_ifid, bubble, flush, busy, cnt}.
   function automatic logic [24:0] actual(input int inst);
      case (inst)
         0:       actual = {fwd0, sp0, si0, bb0, fl0, lb0, cnt0};
         1:       actual = {fwd1, sp1, si1, bb1, fl1, lb1, cnt1};
         2:       actual = {fwd2, sp2, si2, bb2, fl2, lb2, cnt2};
         default: actual = {fwd3, sp3, si3, bb3, fl3, lb3, 12'd0, cnt3};
      endcase
   endfunction

   // Monitor: compare the DUT outputs against the scoreboard once per cycle on the falling edge.
   initial begin
      exp_t        e;
      logic [24:0] a;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = actual(e.inst);
            checks++;
            if (a !== e.v) begin
               errors++;
               $display("FAIL %s (u%0d): got fwd=%b sp=%b si=%b bub=%b fl=%b busy=%b cnt=%0d, want fwd=%b sp=%b si=%b bub=%b fl=%b busy=%b cnt=%0d",
                        e.name, e.inst, a[24:21], a[20], a[19], a[18], a[17], a[16], a[15:0],
                        e.v[24:21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
            end
         end
      end
   end

   // Push the expectation for the current cycle, then advance to the next drive point.
   task automatic expect_cyc(input int inst, input string nm, input logic [3:0] f,
                             input logic st, input logic b, input logic fl,
                             input logic bz, input logic [15:0] c);
      exp_t e;
      e.inst = inst;
      e.name = nm;
      e.v    = {f, st, st, b, fl, bz, c};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_valid = 1'b0; id_src = '0; id_src_use = '0; ex_src = '0; ex_rd = '0;
      ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_rd = '0; mem_wr_en = 1'b0;
      wb_rd = '0; wb_wr_en = 1'b0; mem_stall = 1'b0; flush_req = 1'b0; stat_clr = 1'b0;
   endtask

   // EX holds "lw $5"; ID holds an instruction that reads $5 as operand 0.
   task automatic set_hazard();
      id_valid = 1'b1; id_src = {5'd0, 5'd5}; id_src_use = 2'b01;
      ex_rd = 5'd5; ex_wr_en = 1'b1; ex_is_load = 1'b1;
   endtask

   task automatic reset_pulse();
      clear_in();
      rstb = 1'b0;
      @(posedge clk);
      #1;
      rstb = 1'b1;
   endtask

   initial begin
      rstb = 1'b0;
      clear_in();
      @(posedge clk);
      #1;
      // Check the reset state of every instance.
      for (int k = 0; k < 4; k++) expect_cyc(k, "reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      rstb = 1'b1;

      // Forwarding checks. Operand 0 reads $3 and operand 1 reads $7.
      ex_src = {5'd7, 5'd3};
      mem_rd = 5'd3; mem_wr_en = 1'b1; wb_rd = 5'd3; wb_wr_en = 1'b1;
      expect_cyc(0, "fwd_mem_prio", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      mem_wr_en = 1'b0;
      expect_cyc(0, "fwd_wb", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      mem_wr_en = 1'b1; wb_rd = 5'd7;
      expect_cyc(0, "fwd_both_ops", 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      ex_src = {5'd7, 5'd0}; mem_rd = 5'd0; wb_rd = 5'd0;
      expect_cyc(0, "fwd_r0", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // With LOAD_LAT=1 there is a single bubble and no LU_STALL.
      reset_pulse();
      set_hazard();
      expect_cyc(0, "ll1_bubble", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_in();
      expect_cyc(0, "ll1_done", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

      // With LOAD_LAT=3 there are three bubbles, and lu_busy is high in cycles 2 and 3.
      reset_pulse();
      set_hazard();
      expect_cyc(2, "ll3_c1", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_in();
      expect_cyc(2, "ll3_c2", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1);
      expect_cyc(2, "ll3_c3", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2);
      expect_cyc(2, "ll3_done", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);

      // LOAD_LAT=2 with a two-cycle memory freeze gives 4 stalled cycles and 2 bubbles.
      reset_pulse();
      set_hazard();
      expect_cyc(1, "ms_c1", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_in();
      mem_stall = 1'b1;
      expect_cyc(1, "ms_freeze1", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
      expect_cyc(1, "ms_freeze2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
      mem_stall = 1'b0;
      expect_cyc(1, "ms_resume", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3);
      expect_cyc(1, "ms_done", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

      // A flush in the same cycle as lu_hit prevents entry to LU_STALL.
      reset_pulse();
      set_hazard();
      flush_req = 1'b1;
      expect_cyc(2, "fl_same", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
      clear_in();
      expect_cyc(2, "fl_same_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // A flush in the middle of LU_STALL returns the FSM to IDLE in the next cycle.
      reset_pulse();
      set_hazard();
      expect_cyc(2, "flm_c1", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_in();
      flush_req = 1'b1;
      expect_cyc(2, "flm_flush", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
      flush_req = 1'b0;
      expect_cyc(2, "flm_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

      // An asynchronous reset in the middle of LU_STALL clears the outputs at once.
      reset_pulse();
      set_hazard();
      expect_cyc(2, "rst_c1", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_in();
      expect_cyc(2, "rst_c2", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1);
      rstb = 1'b0;
      expect_cyc(2, "rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      rstb = 1'b1;

      // With CNT_W=4, 20 stalled cycles saturate the counter at 15.
      reset_pulse();
      mem_stall = 1'b1;
      for (int i = 0; i < 20; i++)
         expect_cyc(3, "sat_run", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, (i > 15) ? 16'd15 : 16'(i));
      mem_stall = 1'b0;
      expect_cyc(3, "sat_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd15);
      // stat_clr wins over a concurrent increment.
      mem_stall = 1'b1; stat_clr = 1'b1;
      expect_cyc(3, "clr_vs_inc", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd15);
      mem_stall = 1'b0; stat_clr = 1'b0;
      expect_cyc(3, "clr_done", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Allow the monitor to drain the scoreboard, with a bounded wait.
      for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
